// File: rtl/cpu_dma_tx_pkt_buf.sv
// cpu_dma_tx_pkt_buf: store-and-forward CPU TX buffer, 32-bit DMA words to 64-bit datapath.
// Define CPU_TX_BUF_STATS_EN to build the saturating drop counter behind drop_count.
module cpu_dma_tx_pkt_buf #(
    parameter int          DATA_WIDTH     = 64,
    parameter int          CTRL_WIDTH     = DATA_WIDTH / 8,
    parameter int          DMA_DATA_WIDTH = 32,
    parameter int          DMA_CTRL_WIDTH = 4,
    parameter int          BUF_ADDR_WIDTH = 9,
    parameter int          HDR_ADDR_WIDTH = 3,
    parameter logic [15:0] SRC_PORT       = 16'h0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cpu_q_dma_wr,
    input  logic                      cpu_q_dma_wr_pkt_vld,
    input  logic [DMA_DATA_WIDTH-1:0] cpu_q_dma_wr_data,
    input  logic [DMA_CTRL_WIDTH-1:0] cpu_q_dma_wr_ctrl,
    output logic                      cpu_q_dma_nearly_full,
    output logic [DATA_WIDTH-1:0]     out_data,
    output logic [CTRL_WIDTH-1:0]     out_ctrl,
    output logic                      out_wr,
    input  logic                      out_rdy,
    output logic                      pkt_stored,
    output logic                      pkt_dropped,
    output logic [15:0]               drop_count
);

    localparam int PW     = BUF_ADDR_WIDTH + 1;
    localparam int DEPTH  = 1 << BUF_ADDR_WIDTH;
    localparam int HW     = HDR_ADDR_WIDTH + 1;
    localparam int HDEPTH = 1 << HDR_ADDR_WIDTH;
    localparam int EW     = DATA_WIDTH + CTRL_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA} rd_state_t;

    logic [EW-1:0] buf_mem [DEPTH];
    logic [31:0]   hdr_mem [HDEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] commit_ptr_q, commit_ptr_d;
    logic [PW-1:0] rd_ptr_q;
    logic [HW-1:0] hdr_wr_q, hdr_wr_d;
    logic [HW-1:0] hdr_rd_q;
    logic          half_q, half_d;
    logic [31:0]   hi_q, hi_d;
    logic [15:0]   byte_len_q, byte_len_d;
    logic          bad_q, bad_d;
    logic          stored_q, stored_d;
    logic          dropped_q, dropped_d;
    logic          nf_q, nf_d;

    logic          buf_we;
    logic [EW-1:0] buf_wdata;
    logic          hdr_push;
    logic [31:0]   hdr_wdata;
    logic          eop;
    logic [2:0]    nb;
    logic [15:0]   blen;
    logic [15:0]   wlen;
    logic [7:0]    last_ctrl;
    logic          bad_n;
    logic          need_wr;

    logic [PW-1:0] used;
    logic [HW-1:0] hdr_cnt;
    logic          buf_full;
    logic          hdr_full;
    logic          hdr_empty;

    rd_state_t       state_q;
    logic            out_wr_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic [CTRL_WIDTH-1:0] out_ctrl_q;
    logic [EW-1:0]   rd_entry;
    logic [31:0]     hdr_rdata;

    // Occupancy is measured against the read pointer: committed data still draining is live.
    assign used      = wr_ptr_q - rd_ptr_q;
    assign hdr_cnt   = hdr_wr_q - hdr_rd_q;
    assign buf_full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                       (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);
    assign hdr_full  = (hdr_wr_q[HW-1] != hdr_rd_q[HW-1]) &&
                       (hdr_wr_q[HW-2:0] == hdr_rd_q[HW-2:0]);
    assign hdr_empty = (hdr_wr_q == hdr_rd_q);
    assign rd_entry  = buf_mem[rd_ptr_q[PW-2:0]];
    assign hdr_rdata = hdr_mem[hdr_rd_q[HW-2:0]];

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        hdr_wr_d     = hdr_wr_q;
        half_d       = half_q;
        hi_d         = hi_q;
        byte_len_d   = byte_len_q;
        bad_d        = bad_q;
        stored_d     = 1'b0;
        dropped_d    = 1'b0;
        buf_we       = 1'b0;
        buf_wdata    = '0;
        hdr_push     = 1'b0;
        hdr_wdata    = '0;
        eop          = |cpu_q_dma_wr_ctrl;
        case (1'b1)
            cpu_q_dma_wr_ctrl[0]: nb = 3'd1;
            cpu_q_dma_wr_ctrl[1]: nb = 3'd2;
            cpu_q_dma_wr_ctrl[2]: nb = 3'd3;
            default:              nb = 3'd4;
        endcase
        blen      = byte_len_q + (eop ? {13'h0, nb} : 16'd4);
        wlen      = (blen >> 3) + {15'h0, |blen[2:0]};
        last_ctrl = (half_q ? 8'h08 : 8'h80) >> (nb - 3'd1);
        bad_n     = bad_q | ~cpu_q_dma_wr_pkt_vld;
        need_wr   = half_q | eop;
        nf_d      = (used > PW'(DEPTH - 4)) || (hdr_cnt >= HW'(HDEPTH - 1));

        if (cpu_q_dma_wr) begin
            if (need_wr && buf_full)
                bad_n = 1'b1;
            if (need_wr && !bad_n) begin
                buf_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            buf_wdata = {eop ? last_ctrl : 8'h00,
                         half_q ? {hi_q, cpu_q_dma_wr_data}
                                : {cpu_q_dma_wr_data, 32'h0}};
            if (eop) begin
                half_d     = 1'b0;
                byte_len_d = '0;
                bad_d      = 1'b0;
                if (!bad_n && !hdr_full) begin
                    commit_ptr_d = wr_ptr_d;
                    hdr_push     = 1'b1;
                    hdr_wdata    = {blen, wlen};
                    hdr_wr_d     = hdr_wr_q + 1'b1;
                    stored_d     = 1'b1;
                end else begin
                    wr_ptr_d  = commit_ptr_q;
                    dropped_d = 1'b1;
                end
            end else begin
                half_d     = ~half_q;
                hi_d       = cpu_q_dma_wr_data;
                byte_len_d = blen;
                bad_d      = bad_n;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            hdr_wr_q     <= '0;
            half_q       <= 1'b0;
            hi_q         <= '0;
            byte_len_q   <= '0;
            bad_q        <= 1'b0;
            stored_q     <= 1'b0;
            dropped_q    <= 1'b0;
            nf_q         <= 1'b1;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            hdr_wr_q     <= hdr_wr_d;
            half_q       <= half_d;
            hi_q         <= hi_d;
            byte_len_q   <= byte_len_d;
            bad_q        <= bad_d;
            stored_q     <= stored_d;
            dropped_q    <= dropped_d;
            nf_q         <= nf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we)
            buf_mem[wr_ptr_q[PW-2:0]] <= buf_wdata;
        if (hdr_push)
            hdr_mem[hdr_wr_q[HW-2:0]] <= hdr_wdata;
    end

    // Read side never passes commit_ptr, so partial packets are invisible to it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            rd_ptr_q   <= '0;
            hdr_rd_q   <= '0;
            out_wr_q   <= 1'b0;
            out_data_q <= '0;
            out_ctrl_q <= '0;
        end else begin
            out_wr_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (!hdr_empty)
                        state_q <= S_HDR;
                end
                S_HDR: begin
                    if (out_rdy) begin
                        out_wr_q   <= 1'b1;
                        out_ctrl_q <= '1;
                        out_data_q <= {16'h0, hdr_rdata[15:0],
                                       SRC_PORT, hdr_rdata[31:16]};
                        hdr_rd_q   <= hdr_rd_q + 1'b1;
                        state_q    <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (out_rdy && rd_ptr_q != commit_ptr_q) begin
                        out_wr_q   <= 1'b1;
                        out_ctrl_q <= rd_entry[EW-1 -: CTRL_WIDTH];
                        out_data_q <= rd_entry[DATA_WIDTH-1:0];
                        rd_ptr_q   <= rd_ptr_q + 1'b1;
                        if (rd_entry[EW-1 -: CTRL_WIDTH] != '0)
                            state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cpu_q_dma_nearly_full = nf_q;
    assign out_wr                = out_wr_q;
    assign out_data              = out_data_q;
    assign out_ctrl              = out_ctrl_q;
    assign pkt_stored            = stored_q;
    assign pkt_dropped           = dropped_q;

`ifdef CPU_TX_BUF_STATS_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (dropped_q && drop_cnt_q != 16'hFFFF)
            drop_cnt_d = drop_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            drop_cnt_q <= '0;
        else
            drop_cnt_q <= drop_cnt_d;
    end

    assign drop_count = drop_cnt_q;
`else
    assign drop_count = 16'h0;
`endif

endmodule

// File: tb/tb_cpu_dma_tx_pkt_buf.sv
// Bench for cpu_dma_tx_pkt_buf: directed cases plus randomized packets checked
// against a byte-level packet model.
module tb_cpu_dma_tx_pkt_buf;

    localparam logic [15:0] SRC = 16'h00A5;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr;
    logic        vld;
    logic [31:0] wdata;
    logic [3:0]  wctrl;
    logic        nf;
    logic [63:0] out_data;
    logic [7:0]  out_ctrl;
    logic        out_wr;
    logic        out_rdy;
    logic        pkt_stored;
    logic        pkt_dropped;
    logic [15:0] drop_count;

    always #5 clk = ~clk;

    cpu_dma_tx_pkt_buf #(.SRC_PORT(SRC)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .cpu_q_dma_wr          (wr),
        .cpu_q_dma_wr_pkt_vld  (vld),
        .cpu_q_dma_wr_data     (wdata),
        .cpu_q_dma_wr_ctrl     (wctrl),
        .cpu_q_dma_nearly_full (nf),
        .out_data              (out_data),
        .out_ctrl              (out_ctrl),
        .out_wr                (out_wr),
        .out_rdy               (out_rdy),
        .pkt_stored            (pkt_stored),
        .pkt_dropped           (pkt_dropped),
        .drop_count            (drop_count)
    );

    int checks = 0;
    int failures = 0;
    logic [71:0] exp_q[$];
    logic [63:0] msk_q[$];
    logic [71:0] obs_q[$];
    int n_stored = 0;
    int n_dropped = 0;
    int exp_stored = 0;
    int exp_drops = 0;
    bit rdy_rand = 1'b0;

    always @(negedge clk) begin
        if (out_wr) obs_q.push_back({out_ctrl, out_data});
        if (pkt_stored) n_stored++;
        if (pkt_dropped) n_dropped++;
    end

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rdy_rand) out_rdy = ($urandom_range(0, 3) != 0);
    endtask

    // Expected stream: header, then bytes packed 8 per word, first byte in [63:56].
    task automatic model_pkt(input logic [7:0] b[$]);
        int n, wl, v;
        logic [63:0] d, m;
        n  = b.size();
        wl = (n + 7) / 8;
        exp_q.push_back({8'hFF, 16'h0, 16'(wl), SRC, 16'(n)});
        msk_q.push_back('1);
        for (int w = 0; w < wl; w++) begin
            d = '0;
            m = '0;
            v = 0;
            for (int k = 0; k < 8; k++) begin
                if (w * 8 + k < n) begin
                    d[63-8*k -: 8] = b[w*8+k];
                    m[63-8*k -: 8] = 8'hFF;
                    v++;
                end
            end
            exp_q.push_back({(w == wl - 1) ? 8'(1 << (8 - v)) : 8'h00, d});
            msk_q.push_back(m);
        end
    endtask

    task automatic send_pkt(input logic [7:0] b[$], input int bad_w, input bit honor);
        int n, nw, rem, g;
        logic [31:0] d;
        n  = b.size();
        nw = (n + 3) / 4;
        for (int w = 0; w < nw; w++) begin
            if (honor) begin
                g = 0;
                while (nf && g < 4000) begin
                    tick();
                    g++;
                end
                if (g >= 4000) chk("nf_wait_timeout", 72'(nf), 72'(0));
            end
            rem = n - 4 * w;
            for (int k = 0; k < 4; k++)
                d[31-8*k -: 8] = (k < rem) ? b[4*w+k] : 8'($urandom);
            wr    = 1'b1;
            vld   = (w != bad_w);
            wdata = d;
            wctrl = (rem <= 4) ? 4'(1 << (rem - 1)) : 4'h0;
            tick();
        end
        wr    = 1'b0;
        vld   = 1'b0;
        wctrl = 4'h0;
    endtask

    task automatic rand_pkt(input int n, output logic [7:0] b[$]);
        b = {};
        for (int i = 0; i < n; i++) b.push_back(8'($urandom));
    endtask

    task automatic wait_obs(input int cnt, input string tag);
        int g;
        g = 0;
        while (obs_q.size() < cnt && g < 2000) begin
            tick();
            g++;
        end
        if (g >= 2000) chk({tag, "_timeout"}, 72'(obs_q.size()), 72'(cnt));
    endtask

    task automatic drain_check(input string tag);
        int g;
        logic [71:0] o, e;
        logic [63:0] m;
        rdy_rand = 1'b0;
        out_rdy  = 1'b1;
        g = 0;
        while (obs_q.size() < exp_q.size() && g < 20000) begin
            tick();
            g++;
        end
        repeat (8) tick();
        chk({tag, "_words"}, 72'(obs_q.size()), 72'(exp_q.size()));
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            m = msk_q.pop_front();
            chk(tag, {o[71:64], o[63:0] & m}, e);
        end
        exp_q.delete();
        msk_q.delete();
        obs_q.delete();
        chk({tag, "_stored"}, 72'(n_stored), 72'(exp_stored));
        chk({tag, "_dropped"}, 72'(n_dropped), 72'(exp_drops));
`ifdef CPU_TX_BUF_STATS_EN
        chk({tag, "_drop_count"}, 72'(drop_count), 72'(exp_drops > 65535 ? 65535 : exp_drops));
`else
        chk({tag, "_drop_count"}, 72'(drop_count), 72'(0));
`endif
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_out_wr"}, 72'(out_wr), 72'(0));
        chk({tag, "_out_data"}, 72'(out_data), 72'(0));
        chk({tag, "_out_ctrl"}, 72'(out_ctrl), 72'(0));
        chk({tag, "_stored"}, 72'(pkt_stored), 72'(0));
        chk({tag, "_dropped"}, 72'(pkt_dropped), 72'(0));
        chk({tag, "_drop_count"}, 72'(drop_count), 72'(0));
        chk({tag, "_nf"}, 72'(nf), 72'(1));
    endtask

    initial begin
        logic [7:0] pkt[$];
        int n, bad;

        reset   = 1'b1;
        wr      = 1'b0;
        vld     = 1'b0;
        wdata   = '0;
        wctrl   = '0;
        out_rdy = 1'b0;
        #1;
        check_reset_outputs("rst");
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
        tick();
        chk("idle_nf", 72'(nf), 72'(0));
        out_rdy = 1'b1;

        // Three-word packet, 12 bytes
        pkt = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                8'h08, 8'h09, 8'hAA, 8'h55};
        model_pkt(pkt);
        exp_stored++;
        send_pkt(pkt, -1, 1'b1);
        wait_obs(3, "t1");
        chk("t1_hdr", obs_q[0], {8'hFF, 64'h0000_0002_00A5_000C});
        chk("t1_w0", obs_q[1], {8'h00, 64'h0001_0203_0405_0607});
        chk("t1_w1", 72'(obs_q[2][71:32]), 72'({8'h10, 32'h0809AA55}));
        drain_check("t1");

        // One-byte packet
        pkt = '{8'hDE};
        model_pkt(pkt);
        exp_stored++;
        send_pkt(pkt, -1, 1'b1);
        wait_obs(2, "t2");
        chk("t2_hdr", obs_q[0], {8'hFF, 64'h0000_0001_00A5_0001});
        chk("t2_w0", 72'(obs_q[1][71:56]), 72'({8'h80, 8'hDE}));
        drain_check("t2");

        // pkt_vld low on the second word
        rand_pkt(16, pkt);
        exp_drops++;
        send_pkt(pkt, 1, 1'b1);
        repeat (4) tick();
        chk("t3_nf", 72'(nf), 72'(0));
        drain_check("t3");

        // Overflow: 1031 words ignoring nearly_full, then a clean 8-byte packet
        rand_pkt(1031 * 4, pkt);
        exp_drops++;
        send_pkt(pkt, -1, 1'b0);
        repeat (4) tick();
        chk("t4_nf_after_drop", 72'(nf), 72'(0));
        rand_pkt(8, pkt);
        model_pkt(pkt);
        exp_stored++;
        send_pkt(pkt, -1, 1'b1);
        drain_check("t4");

        // Header FIFO fill with out_rdy held low
        out_rdy = 1'b0;
        for (int p = 0; p < 8; p++) begin
            rand_pkt(8, pkt);
            model_pkt(pkt);
            exp_stored++;
            send_pkt(pkt, -1, 1'b0);
            repeat (3) tick();
            if (p == 5) chk("t5_nf_at_6", 72'(nf), 72'(0));
            if (p == 6) chk("t5_nf_at_7", 72'(nf), 72'(1));
        end
        chk("t5_held", 72'(obs_q.size()), 72'(0));
        drain_check("t5");

        // Randomized packets, random out_rdy, occasional invalid word
        rdy_rand = 1'b1;
        for (int p = 0; p < 60; p++) begin
            n = $urandom_range(1, 200);
            rand_pkt(n, pkt);
            bad = ($urandom_range(0, 7) == 0) ? $urandom_range(0, (n + 3) / 4 - 1) : -1;
            if (bad < 0) begin
                model_pkt(pkt);
                exp_stored++;
            end else begin
                exp_drops++;
            end
            send_pkt(pkt, bad, 1'b1);
            tick();
            tick();
        end
        drain_check("rand");

        // Reset in the middle of an incoming packet
        out_rdy = 1'b1;
        wr      = 1'b1;
        vld     = 1'b1;
        wctrl   = 4'h0;
        wdata   = 32'h1122_3344;
        tick();
        wdata   = 32'h5566_7788;
        tick();
        wr      = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        check_reset_outputs("rst_mid_pkt");
        tick();
        reset = 1'b0;
        n_stored   = 0;
        n_dropped  = 0;
        exp_stored = 0;
        exp_drops  = 0;
        tick();
        tick();

        // Reset in the middle of a drain
        rand_pkt(160, pkt);
        model_pkt(pkt);
        send_pkt(pkt, -1, 1'b1);
        wait_obs(4, "t6_drain");
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("rst_mid_drain");
        tick();
        tick();
        reset = 1'b0;
        exp_q.delete();
        msk_q.delete();
        obs_q.delete();
        n_stored   = 0;
        n_dropped  = 0;
        exp_stored = 0;
        exp_drops  = 0;
        tick();
        tick();
        rand_pkt(24, pkt);
        model_pkt(pkt);
        exp_stored++;
        send_pkt(pkt, -1, 1'b1);
        drain_check("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
